// File: rtl/nn_fp_pkg.sv
// nn_fp_pkg: shared float format defaults, exception flag indices and activation constants
package nn_fp_pkg;
  localparam int EXP_WIDTH = 8;
  localparam int MANT_WIDTH = 24;
  localparam int EXC_WIDTH = 5;
  localparam int EXC_INEXACT = 0;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_OVERFLOW = 2;
  localparam int EXC_DIVZERO = 3;
  localparam int EXC_INVALID = 4;
  localparam int ACT_LEAK_SHIFT = 4;
endpackage

// File: rtl/fp_relu.sv
// fp_relu: combinational per-element ReLU; LEAKY_RELU_EN scales negatives by 2^-ACT_LEAK_SHIFT
module fp_relu
  import nn_fp_pkg::*;
#(
  parameter int exp_width = EXP_WIDTH,
  parameter int mant_width = MANT_WIDTH
) (
  input  logic [exp_width+mant_width-1:0] x,
  output logic [exp_width+mant_width-1:0] y
);
  localparam int dw = exp_width + mant_width;
  logic sign;
  logic [exp_width-1:0] e;
  logic [mant_width-2:0] f;
  logic nan;
  always_comb begin
    sign = x[dw-1];
    e = x[dw-2 -: exp_width];
    f = x[mant_width-2:0];
    nan = &e && |f;
`ifdef LEAKY_RELU_EN
    y = (!sign || &e) ? x
      : (e > exp_width'(ACT_LEAK_SHIFT)) ? {sign, e - exp_width'(ACT_LEAK_SHIFT), f} : '0;
`else
    y = (!sign || nan) ? x : '0;
`endif
  end
endmodule

// File: rtl/layer_activation_stage.sv
// layer_activation_stage: ReLU on a 2-element vector into a 2-entry output FIFO; LEAKY_RELU_EN selects leaky mode
module layer_activation_stage
  import nn_fp_pkg::*;
#(
  parameter int exp_width = EXP_WIDTH,
  parameter int mant_width = MANT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [exp_width+mant_width-1:0] c1,
  input  logic [exp_width+mant_width-1:0] c2,
  input  logic [EXC_WIDTH-1:0]            exceptions_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [exp_width+mant_width-1:0] y1,
  output logic [exp_width+mant_width-1:0] y2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXC_WIDTH-1:0]            sticky_exc,
  input  logic                            clear_sticky,
  output logic [15:0]                     beat_count
);
  localparam int dw = exp_width + mant_width;
  logic [dw-1:0] a1, a2;
  logic [1:0][2*dw-1:0] mem;
  logic wr_ptr, rd_ptr, live, push, pop;
  logic [1:0] count;
  fp_relu #(.exp_width(exp_width), .mant_width(mant_width)) u_relu1 (.x(c1), .y(a1));
  fp_relu #(.exp_width(exp_width), .mant_width(mant_width)) u_relu2 (.x(c2), .y(a2));
  // live holds in_ready low until the first edge after reset release
  assign in_ready = live && count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {y1, y2} = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      live <= 1'b0;
      sticky_exc <= '0;
      beat_count <= 16'd0;
    end else begin
      live <= 1'b1;
      if (push) mem[wr_ptr] <= {a1, a2};
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + 2'(push) - 2'(pop);
      sticky_exc <= clear_sticky ? (push ? exceptions_in : '0) : (push ? sticky_exc | exceptions_in : sticky_exc);
      beat_count <= beat_count + 16'(push);
    end
  end
endmodule

// File: tb/tb_layer_activation_stage.sv
// tb_layer_activation_stage: scoreboard bench for layer_activation_stage
module tb_layer_activation_stage;
  logic clk = 0, rst_n = 0;
  logic [31:0] c1 = 0, c2 = 0;
  logic [4:0] exc = 0;
  logic in_valid = 0, out_ready = 0, clear_sticky = 0;
  logic in_ready, out_valid;
  logic [31:0] y1, y2;
  logic [4:0] sticky_exc;
  logic [15:0] beat_count;
  int checks = 0, passes = 0, delivered = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  layer_activation_stage dut (
    .clk(clk), .rst_n(rst_n), .c1(c1), .c2(c2), .exceptions_in(exc),
    .in_valid(in_valid), .in_ready(in_ready), .y1(y1), .y2(y2),
    .out_valid(out_valid), .out_ready(out_ready), .sticky_exc(sticky_exc),
    .clear_sticky(clear_sticky), .beat_count(beat_count)
  );

  function automatic logic [31:0] act(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (!x[31] || (e == 8'hFF && x[22:0] != 0)) return x;
`ifdef LEAKY_RELU_EN
    if (e == 8'hFF) return x;
    if (e > 8'd4) return {1'b1, e - 8'd4, x[22:0]};
`endif
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL pop_unexpected got=%h_%h want=none", y1, y2);
        else begin
          if ({y1, y2} !== sb[0]) $display("FAIL pop_data got=%h_%h want=%h_%h", y1, y2, sb[0][63:32], sb[0][31:0]);
          else passes++;
          void'(sb.pop_front());
        end
        delivered++;
      end
      if (in_valid && in_ready) sb.push_back({act(c1), act(c2)});
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] e);
    int n = 0;
    c1 = a; c2 = b; exc = e; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout got=in_ready0 want=in_ready1");
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0) $display("FAIL drain got=%0d want=0", sb.size());
    else passes++;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, in_ready, beat_count, sticky_exc, y1, y2} !== '0)
      $display("FAIL reset_state got=%b%b_%h_%b_%h_%h want=all0", out_valid, in_ready, beat_count, sticky_exc, y1, y2);
    else passes++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", in_ready); else passes++;
  endtask

  task automatic test_pass();
    out_ready = 1;
    drive(32'h40A00000, 32'h40400000, 5'b0);
    checks++;
    if ({out_valid, y1, y2} !== {1'b1, 32'h40A00000, 32'h40400000})
      $display("FAIL pass_out got=%b_%h_%h want=1_40a00000_40400000", out_valid, y1, y2);
    else passes++;
    checks++;
    if (beat_count !== 16'd1) $display("FAIL pass_count got=%0d want=1", beat_count); else passes++;
    drain();
  endtask

  task automatic test_negative();
    logic [31:0] w1;
`ifdef LEAKY_RELU_EN
    w1 = 32'hBD800000;
`else
    w1 = 32'h00000000;
`endif
    out_ready = 1;
    drive(32'hBF800000, 32'h80000000, 5'b0);
    checks++;
    if ({y1, y2} !== {w1, 32'h0}) $display("FAIL negative got=%h_%h want=%h_00000000", y1, y2, w1);
    else passes++;
    drive(32'hFF800000, 32'h80000001, 5'b0);
    drive(32'h82000000, 32'hC1200000, 5'b0);
    drain();
  endtask

  task automatic test_nan_sticky();
    out_ready = 1;
    drive(32'h7FC00000, 32'hFFC00001, 5'b10000);
    checks++;
    if ({y1, y2} !== {32'h7FC00000, 32'hFFC00001}) $display("FAIL nan_pass got=%h_%h want=7fc00000_ffc00001", y1, y2);
    else passes++;
    drive(32'h3F800000, 32'h0, 5'b00001);
    checks++;
    if (sticky_exc !== 5'b10001) $display("FAIL sticky_or got=%b want=10001", sticky_exc); else passes++;
    clear_sticky = 1;
    @(posedge clk); #1;
    clear_sticky = 0;
    checks++;
    if (sticky_exc !== 5'b0) $display("FAIL sticky_clear got=%b want=00000", sticky_exc); else passes++;
    drive(32'h1, 32'h2, 5'b00010);
    clear_sticky = 1;
    drive(32'h3, 32'h4, 5'b00100);
    clear_sticky = 0;
    checks++;
    if (sticky_exc !== 5'b00100) $display("FAIL sticky_clear_beat got=%b want=00100", sticky_exc); else passes++;
    drain();
  endtask

  task automatic test_backpressure();
    int d0 = delivered;
    logic [15:0] b0 = beat_count;
    out_ready = 0;
    drive(32'h41000000, 32'hC1000000, 5'b0);
    drive(32'h41100000, 32'h3F000000, 5'b0);
    c1 = 32'h41200000; c2 = 32'hBF000000; in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, beat_count} !== {1'b0, 16'(b0 + 16'd2)}) $display("FAIL full_stall got=%b_%0d want=0_%0d", in_ready, beat_count, b0 + 16'd2);
    else passes++;
    checks++;
    if ({out_valid, y1} !== {1'b1, 32'h41000000}) $display("FAIL hold_head got=%b_%h want=1_41000000", out_valid, y1);
    else passes++;
    out_ready = 1;
    drive(32'h41200000, 32'hBF000000, 5'b0);
    drain();
    checks++;
    if (delivered - d0 != 3) $display("FAIL bp_delivered got=%0d want=3", delivered - d0); else passes++;
  endtask

  task automatic test_back_to_back();
    int d0 = delivered;
    out_ready = 1;
    for (int i = 0; i < 6; i++) drive(32'h40000000 + i, 32'h80000000 | i, 5'b0);
    checks++;
    if ({out_valid, in_ready} !== 2'b11) $display("FAIL b2b_state got=%b%b want=11", out_valid, in_ready); else passes++;
    drain();
    checks++;
    if (delivered - d0 != 6) $display("FAIL b2b_delivered got=%0d want=6", delivered - d0); else passes++;
  endtask

  task automatic test_reset_midflight();
    out_ready = 0;
    drive(32'h1234, 32'h5678, 5'b01000);
    drive(32'h9ABC, 32'hDEF0, 5'b0);
    #2 rst_n = 0;
    #1;
    sb.delete();
    checks++;
    if ({out_valid, in_ready, beat_count, sticky_exc} !== '0)
      $display("FAIL midreset got=%b%b_%h_%b want=all0", out_valid, in_ready, beat_count, sticky_exc);
    else passes++;
    @(negedge clk); rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL midreset_recover got=%b%b want=10", in_ready, out_valid); else passes++;
  endtask

  task automatic test_wrap();
    out_ready = 1;
    for (int i = 0; i < 65535; i++) drive(i, ~i, 5'b0);
    checks++;
    if (beat_count !== 16'hFFFF) $display("FAIL wrap_pre got=%h want=ffff", beat_count); else passes++;
    drive(32'h7F800000, 32'hFF800000, 5'b0);
    checks++;
    if (beat_count !== 16'h0000) $display("FAIL wrap got=%h want=0000", beat_count); else passes++;
    drain();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_negative();
    test_nan_sticky();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
